// File: rtl/bitfield_unit_pkg.sv
// Shared definitions for the bitfield extract/insert unit: widths, opcodes,
// the S1 payload layout and the S2 merge function.
package bitfield_unit_pkg;

   localparam int unsigned DATA_W  = 64;
   localparam int unsigned HALF_W  = 32;
   localparam int unsigned SHAMT_W = 6;

   typedef enum logic [1:0] {
      OPC_SBFM = 2'b00,
      OPC_BFM  = 2'b01,
      OPC_UBFM = 2'b10,
      OPC_RSVD = 2'b11
   } opc_e;

   typedef struct packed {
      opc_e              opc;
      logic              sf;
      logic              sign;
      logic [DATA_W-1:0] rot;
      logic [DATA_W-1:0] wmask;
      logic [DATA_W-1:0] tmask;
      logic [DATA_W-1:0] rd;
   } s1_pl_t;

   // Combine rotated source, destination and fill bits under the two masks.
   function automatic logic [DATA_W-1:0] bf_merge(input s1_pl_t p);
      logic [DATA_W-1:0] bot;
      logic [DATA_W-1:0] top;
      logic [DATA_W-1:0] res;
      bot = p.rot & p.wmask;
      top = '0;
      case (p.opc)
         OPC_SBFM: top = {DATA_W{p.sign}};
         OPC_BFM: begin
            bot = (p.rd & ~p.wmask) | (p.rot & p.wmask);
            top = p.rd;
         end
         default: top = '0;
      endcase
      res = (top & ~p.tmask) | (bot & p.tmask);
      if (p.opc == OPC_RSVD) begin
         res = '0;
      end
      if (!p.sf) begin
         res[DATA_W-1:HALF_W] = '0;
      end
      return res;
   endfunction

endpackage

// File: rtl/bitfield_unit_rotate.sv
// Combinational rotate-right; 64-bit, or 32-bit replicated into both halves.
module bitfield_rotate
   import bitfield_unit_pkg::*;
(
   input  logic [DATA_W-1:0]  i_data,
   input  logic [SHAMT_W-1:0] i_amt,
   input  logic               i_sf,
   output logic [DATA_W-1:0]  o_rot
);

   logic [DATA_W-1:0]  w_rot64;
   logic [HALF_W-1:0]  w_lo;
   logic [HALF_W-1:0]  w_rot32;
   logic [SHAMT_W-2:0] w_amt32;

   // A left shift by the full width yields zero, which covers amount 0.
   assign w_rot64 = (i_data >> i_amt)
                  | (i_data << (7'(DATA_W) - {1'b0, i_amt}));

   assign w_amt32 = i_amt[SHAMT_W-2:0];
   assign w_lo    = i_data[HALF_W-1:0];
   assign w_rot32 = (w_lo >> w_amt32)
                  | (w_lo << (6'(HALF_W) - {1'b0, w_amt32}));

   assign o_rot = i_sf ? w_rot64 : {w_rot32, w_rot32};

endmodule

// File: rtl/bitfield_unit.sv
// Two-stage valid/ready bitfield move unit (SBFM/BFM/UBFM): S1 rotates and
// captures operands, S2 merges under the masks and holds the result.
module bitfield_unit
   import bitfield_unit_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         opc,
   input  logic               sf,
   input  logic [SHAMT_W-1:0] immr,
   input  logic [SHAMT_W-1:0] imms,
   input  logic [DATA_W-1:0]  wmask,
   input  logic [DATA_W-1:0]  tmask,
   input  logic [DATA_W-1:0]  rn_data,
   input  logic [DATA_W-1:0]  rd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  result
);

   logic               r_s1_valid;
   s1_pl_t             r_s1;
   logic               r_s2_valid;
   logic [DATA_W-1:0]  r_result;

   logic               w_s1_adv;
   logic               w_accept;
   logic [DATA_W-1:0]  w_rot;
   logic [SHAMT_W-1:0] w_sign_idx;
   logic               w_sign;
   s1_pl_t             w_s1_next;

   assign w_s1_adv = ~r_s2_valid | out_ready;
   assign in_ready = ~flush & (~r_s1_valid | w_s1_adv);
   assign w_accept = in_valid & in_ready;

   bitfield_rotate u_rotate (
      .i_data (rn_data),
      .i_amt  (immr),
      .i_sf   (sf),
      .o_rot  (w_rot)
   );

   // 32-bit operations take the sign from the low word only.
   assign w_sign_idx = sf ? imms : {1'b0, imms[SHAMT_W-2:0]};
   assign w_sign     = rn_data[w_sign_idx];

   always_comb begin
      w_s1_next       = '0;
      w_s1_next.opc   = opc_e'(opc);
      w_s1_next.sf    = sf;
      w_s1_next.sign  = w_sign;
      w_s1_next.rot   = w_rot;
      w_s1_next.wmask = wmask;
      w_s1_next.tmask = tmask;
      w_s1_next.rd    = rd_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
      end else if (flush) begin
         r_s1_valid <= 1'b0;
      end else begin
         if (in_ready) begin
            r_s1_valid <= in_valid;
         end
         if (w_accept) begin
            r_s1 <= w_s1_next;
         end
      end
   end

   // S2 only loads when S1 advances, so a stalled result stays put.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
      end else if (flush) begin
         r_s2_valid <= 1'b0;
      end else if (w_s1_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result <= bf_merge(r_s1);
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign result    = r_result;

endmodule

// File: tb/tb_bitfield_unit.sv
// Directed bench for bitfield_unit: reference vectors, stall, flush, reset.
module tb_bitfield_unit;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  opc;
   logic        sf;
   logic [5:0]  immr;
   logic [5:0]  imms;
   logic [63:0] wmask;
   logic [63:0] tmask;
   logic [63:0] rn_data;
   logic [63:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]  o;
      logic        s;
      logic [5:0]  r;
      logic [5:0]  m;
      logic [63:0] wm;
      logic [63:0] tm;
      logic [63:0] rn;
      logic [63:0] rd;
      logic [63:0] exp;
   } vec_t;

   bitfield_unit dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opc       (opc),
      .sf        (sf),
      .immr      (immr),
      .imms      (imms),
      .wmask     (wmask),
      .tmask     (tmask),
      .rn_data   (rn_data),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] o, input logic s, input logic [5:0] r,
                        input logic [5:0] m, input logic [63:0] wm, input logic [63:0] tm,
                        input logic [63:0] rn, input logic [63:0] rd);
      in_valid = 1'b1;
      opc      = o;
      sf       = s;
      immr     = r;
      imms     = m;
      wmask    = wm;
      tmask    = tm;
      rn_data  = rn;
      rd_data  = rd;
   endtask

   // Pass-through UBFM: all-ones masks, no rotation, so result = rn.
   task automatic drive_pass(input logic [63:0] rn);
      drive(2'b10, 1'b1, 6'd0, 6'd63, '1, '1, rn, 64'h0);
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      opc = 2'b00; sf = 1'b0; immr = '0; imms = '0;
      wmask = '0; tmask = '0; rn_data = '0; rd_data = '0;
      #2;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
      n_vec++;
      if (result !== 64'h0) begin n_err++; $display("FAIL reset result got %h exp 0", result); end
      tick();
      tick();
      reset = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset idle out_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_vectors();
      vec_t v[9];
      v[0] = '{2'b10, 1'b1, 6'd4,  6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0FFF_FFFF_FFFF_FFFF,
               64'hF000_0000_0000_00F0, 64'h0, 64'h0F00_0000_0000_000F};
      v[1] = '{2'b00, 1'b1, 6'd4,  6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0FFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 64'h0, 64'hF800_0000_0000_0000};
      v[2] = '{2'b01, 1'b1, 6'd56, 6'd3,  64'h0F00, 64'h0FFF,
               64'hA, 64'hFFFF, 64'hFAFF};
      v[3] = '{2'b10, 1'b0, 6'd8,  6'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF_FFFF_00FF_FFFF,
               64'hFFFF_FFFF_1234_5678, 64'h0, 64'h0000_0000_0012_3456};
      v[4] = '{2'b10, 1'b0, 6'd40, 6'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF_FFFF_00FF_FFFF,
               64'hFFFF_FFFF_1234_5678, 64'h0, 64'h0000_0000_0012_3456};
      v[5] = '{2'b00, 1'b0, 6'd0,  6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FFFF,
               64'h0000_0000_8000_0000, 64'h0, 64'h0000_0000_FFFF_0000};
      v[6] = '{2'b11, 1'b1, 6'd4,  6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hDEAD_BEEF_CAFE_F00D, 64'hFFFF, 64'h0};
      v[7] = '{2'b01, 1'b0, 6'd0,  6'd7,  64'h0000_0000_0000_00FF, 64'h0000_0000_FFFF_FFFF,
               64'h55, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0000_0000_AAAA_AA55};
      v[8] = '{2'b00, 1'b1, 6'd0,  6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF,
               64'h1234, 64'h0, 64'h34};
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(v[i].o, v[i].s, v[i].r, v[i].m, v[i].wm, v[i].tm, v[i].rn, v[i].rd);
         #1;
         n_vec++;
         if (in_ready !== 1'b1) begin n_err++; $display("FAIL vec%0d in_ready got %b exp 1", i, in_ready); end
         tick();
         in_valid = 1'b0;
         n_vec++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL vec%0d early out_valid got %b exp 0", i, out_valid); end
         tick();
         n_vec++;
         if (out_valid !== 1'b1) begin n_err++; $display("FAIL vec%0d out_valid got %b exp 1", i, out_valid); end
         n_vec++;
         if (result !== v[i].exp) begin n_err++; $display("FAIL vec%0d result got %h exp %h", i, result, v[i].exp); end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      drive_pass(64'h1111);
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b in_ready A got %b exp 1", in_ready); end
      tick();
      drive_pass(64'h2222);
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b in_ready B got %b exp 1", in_ready); end
      tick();
      drive_pass(64'h3333);
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b in_ready C got %b exp 0", in_ready); end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || result !== 64'h1111) begin
         n_err++; $display("FAIL b2b stall1 got %b/%h exp 1/1111", out_valid, result);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || result !== 64'h1111 || in_ready !== 1'b0) begin
         n_err++; $display("FAIL b2b stall2 got %b/%h/%b exp 1/1111/0", out_valid, result, in_ready);
      end
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b release in_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || result !== 64'h2222) begin
         n_err++; $display("FAIL b2b second got %b/%h exp 1/2222", out_valid, result);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || result !== 64'h3333) begin
         n_err++; $display("FAIL b2b third got %b/%h exp 1/3333", out_valid, result);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b drained out_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive_pass(64'hAAA1);
      tick();
      drive_pass(64'hAAA2);
      tick();
      drive_pass(64'hAAA3);
      flush     = 1'b1;
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush in_ready got %b exp 0", in_ready); end
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush cyc%0d out_valid got %b exp 0", k, out_valid); end
         tick();
      end
      drive_pass(64'h5555);
      tick();
      in_valid = 1'b0;
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || result !== 64'h5555) begin
         n_err++; $display("FAIL flush recover got %b/%h exp 1/5555", out_valid, result);
      end
      tick();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive_pass(64'h7771);
      tick();
      drive_pass(64'h7772);
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL areset pre out_valid got %b exp 1", out_valid); end
      #2;
      reset = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset out_valid got %b exp 0", out_valid); end
      n_vec++;
      if (result !== 64'h0) begin n_err++; $display("FAIL areset result got %h exp 0", result); end
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL areset in_ready got %b exp 1", in_ready); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset cyc%0d out_valid got %b exp 0", k, out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
